// File: rtl/clock_display_scan.sv
// clock_display_scan: 8-digit multiplexed time/date display with a per-frame snapshot and BCD conversion.
// Build option: define LEADING_ZERO_BLANK_EN to blank a zero tens-of-hours / tens-of-days digit.
module clock_display_scan #(
   parameter int unsigned SCAN_DIV = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mode,
   input  logic [5:0]  sec_bin,
   input  logic [5:0]  min_bin,
   input  logic [4:0]  hour_bin,
   input  logic [4:0]  day_bin,
   input  logic [3:0]  month_bin,
   input  logic [13:0] year_bin,
   output logic [6:0]  seg_n,
   output logic        dp_n,
   output logic [7:0]  an_n,
   output logic        frame_start
);
   typedef enum logic [2:0] {IDLE, LOAD, SHIFT, NEXT, COMMIT} state_t;

`ifdef LEADING_ZERO_BLANK_EN
   localparam logic LZB = 1'b1;
`else
   localparam logic LZB = 1'b0;
`endif
   localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  dig_q, dig_d;
   logic        run_q, run_d;
   logic        scan_tick;
   logic [40:0] snap_q, snap_d;
   state_t      state_q, state_d;
   logic [2:0]  fld_q, fld_d;
   logic [3:0]  bit_q, bit_d;
   logic [13:0] bin_q, bin_d;
   logic [15:0] bcd_q, bcd_d, bcd_adj;
   logic [55:0] res_q, res_d, bank_q, bank_d;
   logic        page_q, page_d;
   logic [6:0]  seg_q, seg_d;
   logic        dp_q, dp_d;
   logic [7:0]  an_q, an_d;
   logic [3:0]  nib_s, fw_s;
   logic [13:0] fv_s;
   logic        blank_s, dpl_s;

   function automatic logic [15:0] add3(input logic [15:0] v);
      logic [15:0] r;
      r = v;
      for (int i = 0; i < 4; i++) begin
         if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
         else                     r[i*4 +: 4] = r[i*4 +: 4];
      end
      return r;
   endfunction

   function automatic logic [6:0] seg_code(input logic [3:0] v);
      case (v)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [3:0] fld_width(input logic [2:0] f);
      case (f)
         3'd0, 3'd1: return 4'd6;
         3'd2, 3'd3: return 4'd5;
         3'd4:       return 4'd4;
         default:    return 4'd14;
      endcase
   endfunction

   function automatic logic [13:0] fld_val(input logic [39:0] s, input logic [2:0] f);
      case (f)
         3'd0:    return {8'd0, s[5:0]};
         3'd1:    return {8'd0, s[11:6]};
         3'd2:    return {9'd0, s[16:12]};
         3'd3:    return {9'd0, s[21:17]};
         3'd4:    return {10'd0, s[25:22]};
         default: return s[39:26];
      endcase
   endfunction

   // Prescaler, digit index and frame snapshot
   always_comb begin
      scan_tick = (cnt_q == DIV_LAST);
      cnt_d     = scan_tick ? 16'd0 : cnt_q + 16'd1;
      run_d     = run_q | scan_tick;
      if (scan_tick) dig_d = run_q ? dig_q + 3'd1 : 3'd0;
      else           dig_d = dig_q;
      frame_start = scan_tick & (dig_d == 3'd0) & ~rst;
      if (frame_start)
         snap_d = {mode, (year_bin > 14'd9999) ? 14'd9999 : year_bin,
                   month_bin, day_bin, hour_bin, min_bin, sec_bin};
      else
         snap_d = snap_q;
   end

   // Conversion FSM; LOAD shifts in the field MSB so each field costs width+1 cycles
   always_comb begin
      state_d = state_q;
      fld_d   = fld_q;
      bit_d   = bit_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      res_d   = res_q;
      bank_d  = bank_q;
      page_d  = page_q;
      fw_s    = fld_width(fld_q);
      fv_s    = fld_val(snap_q[39:0], fld_q);
      bcd_adj = add3(bcd_q);
      case (state_q)
         IDLE: begin
            if (frame_start) begin
               state_d = LOAD;
               fld_d   = 3'd0;
            end else begin
               state_d = IDLE;
            end
         end
         LOAD: begin
            bin_d   = fv_s;
            bcd_d   = {15'd0, fv_s[fw_s - 4'd1]};
            bit_d   = fw_s - 4'd2;
            state_d = SHIFT;
         end
         SHIFT: begin
            bcd_d = {bcd_adj[14:0], bin_q[bit_q]};
            if (bit_q == 4'd0) state_d = NEXT;
            else               bit_d   = bit_q - 4'd1;
         end
         NEXT: begin
            case (fld_q)
               3'd0:    res_d[7:0]   = bcd_q[7:0];
               3'd1:    res_d[15:8]  = bcd_q[7:0];
               3'd2:    res_d[23:16] = bcd_q[7:0];
               3'd3:    res_d[31:24] = bcd_q[7:0];
               3'd4:    res_d[39:32] = bcd_q[7:0];
               default: res_d[55:40] = bcd_q;
            endcase
            if (fld_q == 3'd5) begin
               state_d = COMMIT;
            end else begin
               fld_d   = fld_q + 3'd1;
               state_d = LOAD;
            end
         end
         COMMIT: begin
            bank_d  = res_q;
            page_d  = snap_q[40];
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Digit mux and segment encode, latched only on scan_tick
   always_comb begin
      nib_s   = 4'd0;
      blank_s = 1'b1;
      dpl_s   = 1'b0;
      if (!page_q) begin
         case (dig_d)
            3'd0: begin nib_s = bank_q[3:0];   blank_s = 1'b0; end
            3'd1: begin nib_s = bank_q[7:4];   blank_s = 1'b0; end
            3'd2: begin nib_s = bank_q[11:8];  blank_s = 1'b0; dpl_s = 1'b1; end
            3'd3: begin nib_s = bank_q[15:12]; blank_s = 1'b0; end
            3'd4: begin nib_s = bank_q[19:16]; blank_s = 1'b0; dpl_s = 1'b1; end
            3'd5: begin nib_s = bank_q[23:20]; blank_s = LZB && (bank_q[23:20] == 4'd0); end
            default: blank_s = 1'b1;
         endcase
      end else begin
         case (dig_d)
            3'd0: begin nib_s = bank_q[43:40]; blank_s = 1'b0; end
            3'd1: begin nib_s = bank_q[47:44]; blank_s = 1'b0; end
            3'd2: begin nib_s = bank_q[51:48]; blank_s = 1'b0; end
            3'd3: begin nib_s = bank_q[55:52]; blank_s = 1'b0; end
            3'd4: begin nib_s = bank_q[35:32]; blank_s = 1'b0; dpl_s = 1'b1; end
            3'd5: begin nib_s = bank_q[39:36]; blank_s = 1'b0; end
            3'd6: begin nib_s = bank_q[27:24]; blank_s = 1'b0; dpl_s = 1'b1; end
            default: begin nib_s = bank_q[31:28]; blank_s = LZB && (bank_q[31:28] == 4'd0); end
         endcase
      end
      if (scan_tick) begin
         an_d  = ~(8'd1 << dig_d);
         seg_d = blank_s ? 7'h7F : seg_code(nib_s);
         dp_d  = ~dpl_s;
      end else begin
         an_d  = an_q;
         seg_d = seg_q;
         dp_d  = dp_q;
      end
   end

   // State registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= 16'd0;
         dig_q   <= 3'd0;
         run_q   <= 1'b0;
         snap_q  <= 41'd0;
         state_q <= IDLE;
         fld_q   <= 3'd0;
         bit_q   <= 4'd0;
         bin_q   <= 14'd0;
         bcd_q   <= 16'd0;
         res_q   <= 56'd0;
         bank_q  <= 56'd0;
         page_q  <= 1'b0;
         seg_q   <= 7'h7F;
         dp_q    <= 1'b1;
         an_q    <= 8'hFF;
      end else begin
         cnt_q   <= cnt_d;
         dig_q   <= dig_d;
         run_q   <= run_d;
         snap_q  <= snap_d;
         state_q <= state_d;
         fld_q   <= fld_d;
         bit_q   <= bit_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         res_q   <= res_d;
         bank_q  <= bank_d;
         page_q  <= page_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
         an_q    <= an_d;
      end
   end

   assign seg_n = seg_q;
   assign dp_n  = dp_q;
   assign an_n  = an_q;
endmodule

// File: tb/tb_clock_display_scan.sv
// Scoreboard bench for clock_display_scan: expected digit slots are queued, then popped per scanned digit.
module tb_clock_display_scan;
   localparam int DIV = 48;
`ifdef LEADING_ZERO_BLANK_EN
   localparam bit LZ = 1'b1;
`else
   localparam bit LZ = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mode = 1'b0;
   logic [5:0]  sec_bin = 6'd0, min_bin = 6'd0;
   logic [4:0]  hour_bin = 5'd0, day_bin = 5'd0;
   logic [3:0]  month_bin = 4'd0;
   logic [13:0] year_bin = 14'd0;
   logic [6:0]  seg_n;
   logic        dp_n;
   logic [7:0]  an_n;
   logic        frame_start;

   typedef struct packed {
      logic [7:0] an;
      logic [6:0] seg;
      logic       dp;
   } disp_t;

   disp_t exp_q[$];
   int vectors = 0;
   int errors  = 0;

   clock_display_scan #(.SCAN_DIV(DIV)) dut (
      .clk(clk), .rst(rst), .mode(mode),
      .sec_bin(sec_bin), .min_bin(min_bin), .hour_bin(hour_bin), .day_bin(day_bin),
      .month_bin(month_bin), .year_bin(year_bin),
      .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n), .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] seg_of(int v);
      case (v)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   // v < 0 means a blank digit
   function automatic disp_t mk(int d, int v, bit dp);
      disp_t r;
      r.an  = ~(8'd1 << d);
      r.seg = (v < 0) ? 7'h7F : seg_of(v);
      r.dp  = ~dp;
      return r;
   endfunction

   task automatic push_time(int h, int m, int s);
      int h1;
      h1 = h / 10;
      if (LZ && h1 == 0) h1 = -1;
      exp_q.push_back(mk(0, s % 10, 1'b0));
      exp_q.push_back(mk(1, s / 10, 1'b0));
      exp_q.push_back(mk(2, m % 10, 1'b1));
      exp_q.push_back(mk(3, m / 10, 1'b0));
      exp_q.push_back(mk(4, h % 10, 1'b1));
      exp_q.push_back(mk(5, h1, 1'b0));
      exp_q.push_back(mk(6, -1, 1'b0));
      exp_q.push_back(mk(7, -1, 1'b0));
   endtask

   task automatic push_date(int dd, int mo, int y);
      int d1, ys;
      ys = (y > 9999) ? 9999 : y;
      d1 = dd / 10;
      if (LZ && d1 == 0) d1 = -1;
      exp_q.push_back(mk(0, ys % 10, 1'b0));
      exp_q.push_back(mk(1, (ys / 10) % 10, 1'b0));
      exp_q.push_back(mk(2, (ys / 100) % 10, 1'b0));
      exp_q.push_back(mk(3, ys / 1000, 1'b0));
      exp_q.push_back(mk(4, mo % 10, 1'b1));
      exp_q.push_back(mk(5, mo / 10, 1'b0));
      exp_q.push_back(mk(6, dd % 10, 1'b1));
      exp_q.push_back(mk(7, d1, 1'b0));
   endtask

   // Wait (bounded) for frame_start, then sample the eight digit slots of that frame.
   // flip_k >= 1 toggles mode just before waiting for digit flip_k.
   task automatic grab_frame(output disp_t obs [0:7], output bit ok, input int flip_k);
      for (int k = 0; k < 8; k++) obs[k] = '0;
      ok = 1'b0;
      for (int i = 0; i < 8 * DIV + 16; i++) begin
         @(negedge clk);
         if (frame_start === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      if (ok) begin
         @(negedge clk);
         obs[0] = {an_n, seg_n, dp_n};
         for (int k = 1; k < 8; k++) begin
            if (k == flip_k) mode = ~mode;
            repeat (DIV) @(negedge clk);
            obs[k] = {an_n, seg_n, dp_n};
         end
      end
   endtask

   task automatic test_reset();
      bit bad;
      rst = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      vectors++;
      if ({an_n, seg_n, dp_n, frame_start} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL reset_hold: got an=%h seg=%b dp=%b fs=%b, expected an=ff seg=1111111 dp=1 fs=0",
                  an_n, seg_n, dp_n, frame_start);
      end
      rst = 1'b0;
      bad = 1'b0;
      for (int i = 1; i < DIV; i++) begin
         @(negedge clk);
         if ({an_n, seg_n, dp_n} !== {8'hFF, 7'h7F, 1'b1}) bad = 1'b1;
         if (i < DIV - 1 && frame_start !== 1'b0) bad = 1'b1;
      end
      vectors++;
      if (bad) begin
         errors++;
         $display("FAIL dark_after_reset: got lit output or early frame_start, expected dark until first tick");
      end
      vectors++;
      if (frame_start !== 1'b1) begin
         errors++;
         $display("FAIL first_frame_start: got %b, expected 1", frame_start);
      end
      @(negedge clk);
      vectors++;
      if (an_n !== 8'hFE) begin
         errors++;
         $display("FAIL first_an: got %h, expected fe", an_n);
      end
      vectors++;
      if (seg_n !== 7'b1000000) begin
         errors++;
         $display("FAIL first_seg: got %b, expected 1000000", seg_n);
      end
      vectors++;
      if (dp_n !== 1'b1) begin
         errors++;
         $display("FAIL first_dp: got %b, expected 1", dp_n);
      end
   endtask

   task automatic test_time_page();
      disp_t obs [0:7];
      disp_t e;
      bit ok;
      mode = 1'b0; hour_bin = 5'd13; min_bin = 6'd5; sec_bin = 6'd59;
      grab_frame(obs, ok, -1);
      push_time(13, 5, 59);
      grab_frame(obs, ok, -1);
      vectors++;
      if (!ok) begin errors++; $display("FAIL time_timeout: got no frame_start, expected one"); end
      for (int k = 0; k < 8; k++) begin
         e = exp_q.pop_front();
         vectors++;
         if (obs[k] !== e) begin
            errors++;
            $display("FAIL time_d%0d: got an=%h seg=%b dp=%b, expected an=%h seg=%b dp=%b",
                     k, obs[k].an, obs[k].seg, obs[k].dp, e.an, e.seg, e.dp);
         end
      end
   endtask

   task automatic test_date_page();
      disp_t obs [0:7];
      disp_t e;
      bit ok;
      mode = 1'b1; day_bin = 5'd31; month_bin = 4'd12; year_bin = 14'd2024;
      grab_frame(obs, ok, -1);
      push_date(31, 12, 2024);
      grab_frame(obs, ok, -1);
      vectors++;
      if (!ok) begin errors++; $display("FAIL date_timeout: got no frame_start, expected one"); end
      for (int k = 0; k < 8; k++) begin
         e = exp_q.pop_front();
         vectors++;
         if (obs[k] !== e) begin
            errors++;
            $display("FAIL date_d%0d: got an=%h seg=%b dp=%b, expected an=%h seg=%b dp=%b",
                     k, obs[k].an, obs[k].seg, obs[k].dp, e.an, e.seg, e.dp);
         end
      end
   endtask

   // Starts from the settled date page of the previous test; mode flips to time mid-frame.
   task automatic test_mode_switch();
      disp_t obs [0:7];
      disp_t e;
      bit ok;
      push_date(31, 12, 2024);
      grab_frame(obs, ok, 3);
      vectors++;
      if (!ok) begin errors++; $display("FAIL switch_timeout: got no frame_start, expected one"); end
      for (int k = 0; k < 8; k++) begin
         e = exp_q.pop_front();
         vectors++;
         if (obs[k] !== e) begin
            errors++;
            $display("FAIL switch_hold_d%0d: got an=%h seg=%b dp=%b, expected an=%h seg=%b dp=%b",
                     k, obs[k].an, obs[k].seg, obs[k].dp, e.an, e.seg, e.dp);
         end
      end
      push_time(13, 5, 59);
      exp_q[0] = mk(0, 4, 1'b0);
      grab_frame(obs, ok, -1);
      for (int k = 0; k < 8; k++) begin
         e = exp_q.pop_front();
         vectors++;
         if (obs[k] !== e) begin
            errors++;
            $display("FAIL switch_new_d%0d: got an=%h seg=%b dp=%b, expected an=%h seg=%b dp=%b",
                     k, obs[k].an, obs[k].seg, obs[k].dp, e.an, e.seg, e.dp);
         end
      end
   endtask

   task automatic test_leading_zero();
      disp_t obs [0:7];
      disp_t e;
      bit ok;
      mode = 1'b0; hour_bin = 5'd7; min_bin = 6'd0; sec_bin = 6'd0;
      grab_frame(obs, ok, -1);
      push_time(7, 0, 0);
      grab_frame(obs, ok, -1);
      for (int k = 0; k < 8; k++) begin
         e = exp_q.pop_front();
         vectors++;
         if (obs[k] !== e) begin
            errors++;
            $display("FAIL lz_d%0d: got an=%h seg=%b dp=%b, expected an=%h seg=%b dp=%b",
                     k, obs[k].an, obs[k].seg, obs[k].dp, e.an, e.seg, e.dp);
         end
      end
   endtask

   task automatic test_saturation();
      disp_t obs [0:7];
      disp_t e;
      bit ok;
      mode = 1'b1; day_bin = 5'd1; month_bin = 4'd9; year_bin = 14'd12000;
      grab_frame(obs, ok, -1);
      push_date(1, 9, 12000);
      grab_frame(obs, ok, -1);
      for (int k = 0; k < 8; k++) begin
         e = exp_q.pop_front();
         vectors++;
         if (obs[k] !== e) begin
            errors++;
            $display("FAIL sat_d%0d: got an=%h seg=%b dp=%b, expected an=%h seg=%b dp=%b",
                     k, obs[k].an, obs[k].seg, obs[k].dp, e.an, e.seg, e.dp);
         end
      end
      mode = 1'b0; sec_bin = 6'd63; min_bin = 6'd40; hour_bin = 5'd23;
      grab_frame(obs, ok, -1);
      push_time(23, 40, 63);
      grab_frame(obs, ok, -1);
      for (int k = 0; k < 8; k++) begin
         e = exp_q.pop_front();
         vectors++;
         if (obs[k] !== e) begin
            errors++;
            $display("FAIL sec63_d%0d: got an=%h seg=%b dp=%b, expected an=%h seg=%b dp=%b",
                     k, obs[k].an, obs[k].seg, obs[k].dp, e.an, e.seg, e.dp);
         end
      end
   endtask

   task automatic test_reset_mid_conversion();
      disp_t obs [0:7];
      disp_t e;
      bit ok, bad;
      mode = 1'b1; day_bin = 5'd28; month_bin = 4'd11; year_bin = 14'd8765;
      ok = 1'b0;
      for (int i = 0; i < 8 * DIV + 16; i++) begin
         @(negedge clk);
         if (frame_start === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      vectors++;
      if (!ok) begin errors++; $display("FAIL midrst_timeout: got no frame_start, expected one"); end
      // 38 cycles after frame_start the year field is shifting
      repeat (38) @(negedge clk);
      rst = 1'b1;
      mode = 1'b0; hour_bin = 5'd12; min_bin = 6'd34; sec_bin = 6'd56;
      repeat (2) @(negedge clk);
      vectors++;
      if ({an_n, seg_n, dp_n, frame_start} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL midrst_dark: got an=%h seg=%b dp=%b fs=%b, expected an=ff seg=1111111 dp=1 fs=0",
                  an_n, seg_n, dp_n, frame_start);
      end
      rst = 1'b0;
      bad = 1'b0;
      for (int i = 1; i < DIV - 1; i++) begin
         @(negedge clk);
         if ({an_n, seg_n, dp_n} !== {8'hFF, 7'h7F, 1'b1}) bad = 1'b1;
      end
      vectors++;
      if (bad) begin errors++; $display("FAIL midrst_stay_dark: got lit output, expected dark"); end
      push_time(12, 34, 56);
      exp_q[0] = mk(0, 0, 1'b0);
      grab_frame(obs, ok, -1);
      for (int k = 0; k < 8; k++) begin
         e = exp_q.pop_front();
         vectors++;
         if (obs[k] !== e) begin
            errors++;
            $display("FAIL midrst_d%0d: got an=%h seg=%b dp=%b, expected an=%h seg=%b dp=%b",
                     k, obs[k].an, obs[k].seg, obs[k].dp, e.an, e.seg, e.dp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_time_page();
      test_date_page();
      test_mode_switch();
      test_leading_zero();
      test_saturation();
      test_reset_mid_conversion();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
